// File: rtl/seq_detect_scheduler.sv
// Round-robin front end that shares one Mealy sequence detector between two
// requesters, serialising 4-bit frames MSB-first and collecting per-frame results.
module seq_detect_scheduler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_data,
    output logic             req1_ready,
    output logic             det_rst_n,
    output logic             det_in,
    input  logic             det_dec,
    output logic             res_valid,
    output logic             res_match,
    output logic             res_id,
    output logic [CNT_W-1:0] match_cnt0,
    output logic [CNT_W-1:0] match_cnt1,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] bidx;
    logic [1:0] bidx_nxt;
    logic       rr;
    logic [3:0] frame;
    logic       owner;

    logic       last_bit;
    logic       grant_opp;
    logic       win0;
    logic       win1;
    logic       grant;

    // A grant can only be issued when the detector is free for a new frame:
    // from IDLE, or on the last bit of the frame currently being shifted.
    always_comb begin
        last_bit  = (state == SHIFT) && (bidx == 2'd3);
        grant_opp = rst_n && ((state == IDLE) || last_bit);
        win0      = grant_opp && req0_valid && (!rr || !req1_valid);
        win1      = grant_opp && req1_valid && (rr || !req0_valid);
        grant     = win0 || win1;
    end

    always_comb begin
        state_nxt = state;
        bidx_nxt  = bidx;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = SYNC;
                end
            end
            SYNC: begin
                state_nxt = SHIFT;
                bidx_nxt  = 2'd0;
            end
            SHIFT: begin
                if (bidx != 2'd3) begin
                    bidx_nxt = bidx + 2'd1;
                end else if (grant) begin
                    // Detector wraps its own counter here, so no SYNC is needed.
                    bidx_nxt = 2'd0;
                end else begin
                    state_nxt = IDLE;
                    bidx_nxt  = 2'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                bidx_nxt  = 2'd0;
            end
        endcase
    end

    assign req0_ready = win0;
    assign req1_ready = win1;
    assign det_rst_n  = rst_n && (state != SYNC);
    assign det_in     = rst_n && (state == SHIFT) && frame[2'd3 - bidx];
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            bidx  <= 2'd0;
            rr    <= 1'b0;
            frame <= 4'd0;
            owner <= 1'b0;
        end else begin
            state <= state_nxt;
            bidx  <= bidx_nxt;
            if (grant) begin
                frame <= win1 ? req1_data : req0_data;
                owner <= win1;
                rr    <= win0;
            end
        end
    end

    // Result capture uses the owner of the finishing frame, before any new grant
    // overwrites it on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_match  <= 1'b0;
            res_id     <= 1'b0;
            match_cnt0 <= '0;
            match_cnt1 <= '0;
        end else begin
            res_valid <= last_bit;
            if (last_bit) begin
                res_match <= det_dec;
                res_id    <= owner;
                if (det_dec) begin
                    if (!owner && (match_cnt0 != CNT_MAX)) begin
                        match_cnt0 <= match_cnt0 + 1'b1;
                    end
                    if (owner && (match_cnt1 != CNT_MAX)) begin
                        match_cnt1 <= match_cnt1 + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Self-checking bench for seq_detect_scheduler with a behavioural model of the
// shared Mealy sequence detector (free-running 4-cycle frame counter).
module tb_seq_detect_scheduler;

    localparam int CNT_W = 2;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic [3:0]       req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [3:0]       req1_data;
    logic             req1_ready;
    logic             det_rst_n;
    logic             det_in;
    logic             det_dec;
    logic             res_valid;
    logic             res_match;
    logic             res_id;
    logic [CNT_W-1:0] match_cnt0;
    logic [CNT_W-1:0] match_cnt1;
    logic             busy;

    int tests;
    int fails;

    seq_detect_scheduler #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .det_rst_n  (det_rst_n),
        .det_in     (det_in),
        .det_dec    (det_dec),
        .res_valid  (res_valid),
        .res_match  (res_match),
        .res_id     (res_id),
        .match_cnt0 (match_cnt0),
        .match_cnt1 (match_cnt1),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector model: counts 0..3, self-resets at 3, flags 0111/1001/1110 on the 4th bit.
    logic [1:0] dcnt;
    logic [2:0] dsh;
    logic [3:0] dword;
    always_ff @(posedge clk) begin
        if (!det_rst_n || dcnt == 2'd3) begin
            dcnt <= 2'd0;
            dsh  <= 3'd0;
        end else begin
            dcnt <= dcnt + 2'd1;
            dsh  <= {dsh[1:0], det_in};
        end
    end
    assign dword   = {dsh, det_in};
    assign det_dec = (dcnt == 2'd3) &&
                     (dword == 4'b0111 || dword == 4'b1001 || dword == 4'b1110);

    typedef struct {
        logic       rst;
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
        logic       r0;
        logic       r1;
        logic       drst;
        logic       din;
        logic       rv;
        logic       rm;
        logic       rid;
        logic       bsy;
        logic [1:0] c0;
        logic [1:0] c1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst_n      = v.rst;
        req0_valid = v.v0;
        req0_data  = v.d0;
        req1_valid = v.v1;
        req1_data  = v.d1;
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string p;
        p = $sformatf("row%0d", idx);
        chk({p, ".req0_ready"}, int'(req0_ready), int'(v.r0));
        chk({p, ".req1_ready"}, int'(req1_ready), int'(v.r1));
        chk({p, ".det_rst_n"},  int'(det_rst_n),  int'(v.drst));
        chk({p, ".det_in"},     int'(det_in),     int'(v.din));
        chk({p, ".res_valid"},  int'(res_valid),  int'(v.rv));
        chk({p, ".res_match"},  int'(res_match),  int'(v.rm));
        chk({p, ".res_id"},     int'(res_id),     int'(v.rid));
        chk({p, ".busy"},       int'(busy),       int'(v.bsy));
        chk({p, ".match_cnt0"}, int'(match_cnt0), int'(v.c0));
        chk({p, ".match_cnt1"}, int'(match_cnt1), int'(v.c1));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 4'd0;
        req1_data  = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single req0 frame from IDLE: checks accept, 6-cycle latency and result.
    task automatic sendFrame(input logic [3:0] f, input int exp_match, input int exp_cnt);
        int k;
        int lat;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = f;
        #1;
        k = 0;
        while (!req0_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk($sformatf("frame%0h.accept", f), int'(req0_ready), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req0_data  = 4'd0;
        #1;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk($sformatf("frame%0h.latency", f), lat, 6);
        chk($sformatf("frame%0h.res_match", f), int'(res_match), exp_match);
        chk($sformatf("frame%0h.res_id", f), int'(res_id), 0);
        chk($sformatf("frame%0h.match_cnt0", f), int'(match_cnt0), exp_cnt);
    endtask

    initial begin
        int cnt;
        int em;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data = 4'd0;
        req1_data = 4'd0;

        // rst, v0, d0, v1, d1 | r0, r1, det_rst_n, det_in, rv, rm, rid, busy, c0, c1
        vecs.push_back('{O,I,4'h7,O,4'h0, O,O,O,O,O,O,O,O,2'd0,2'd0});
        vecs.push_back('{I,I,4'h7,O,4'h0, I,O,I,O,O,O,O,O,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,O,O,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,I,4'h6, O,I,I,O,I,I,O,O,2'd1,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,O,O,O,I,O,I,2'd1,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,O,I,2'd1,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,I,O,I,2'd1,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,I,O,I,2'd1,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,O,I,2'd1,2'd0});
        // Contention: 1001 on req0, 1110 on req1, both held valid.
        vecs.push_back('{I,I,4'h9,I,4'hE, I,O,I,O,I,O,I,O,2'd1,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,O,O,O,O,I,I,2'd1,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,I,O,O,I,I,2'd1,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,O,O,O,I,I,2'd1,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,O,O,O,I,I,2'd1,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,I,I,I,O,O,I,I,2'd1,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,I,I,I,O,I,2'd2,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,I,O,I,O,I,2'd2,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,I,O,I,O,I,2'd2,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, I,O,I,O,O,I,O,I,2'd2,2'd0});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,I,I,I,I,I,2'd2,2'd1});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,O,O,I,I,I,2'd2,2'd1});
        vecs.push_back('{I,I,4'h9,I,4'hE, O,O,I,O,O,I,I,I,2'd2,2'd1});
        vecs.push_back('{I,O,4'h0,I,4'hE, O,I,I,I,O,I,I,I,2'd2,2'd1});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,I,I,O,I,2'd3,2'd1});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,I,O,I,2'd3,2'd1});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,I,O,I,2'd3,2'd1});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,O,I,2'd3,2'd1});
        // Three idle cycles, then 1110 from req1 must pass through SYNC again.
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,I,I,I,O,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,I,O,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,I,O,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,I,4'hE, O,I,I,O,O,I,I,O,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,O,O,O,I,I,I,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,I,I,I,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,I,I,I,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,I,I,I,2'd3,2'd2});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,I,I,2'd3,2'd2});
        // Mid-frame reset during bidx==1, then a clean 0111 frame.
        vecs.push_back('{I,I,4'h7,O,4'h0, I,O,I,O,I,I,I,O,2'd3,2'd3});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,O,O,O,I,I,I,2'd3,2'd3});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,I,I,2'd3,2'd3});
        vecs.push_back('{O,I,4'h7,O,4'h0, O,O,O,O,O,I,I,I,2'd3,2'd3});
        vecs.push_back('{I,I,4'h7,O,4'h0, I,O,I,O,O,O,O,O,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,O,O,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,I,O,O,O,I,2'd0,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,I,I,O,O,2'd1,2'd0});
        vecs.push_back('{I,O,4'h0,O,4'h0, O,O,I,O,O,I,O,O,2'd1,2'd0});

        repeat (2) @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // All 16 frame values through req0: only 0111, 1001, 1110 match.
        doReset();
        cnt = 0;
        for (int f = 0; f < 16; f++) begin
            em = (f == 7 || f == 9 || f == 14) ? 1 : 0;
            if (em == 1 && cnt < 3) cnt++;
            sendFrame(4'(f), em, cnt);
        end

        // Saturation at 2^CNT_W-1: counts read 1,2,3,3,3.
        doReset();
        for (int n = 1; n <= 5; n++) begin
            sendFrame(4'b0111, 1, (n < 3) ? n : 3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_detect_scheduler.md
# seq_detect_scheduler

Shares one `Mealy_Sequence_Detector` instance between two requesters.
- Each requester submits 4-bit frames over a valid/ready handshake; requests are arbitrated round-robin.
- The granted frame is serialised MSB-first onto the detector's `in`, in lock-step with the detector's internal 4-cycle frame counter, and its `dec` is captured on the frame's last bit.
- Per-frame results and per-requester saturating match counts are returned.
- Sits directly in front of the detector in the LAB_4 sequence-detection datapath.

## Interface
- `CNT_W`, default 8: width of each per-requester match counter.

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req0_valid`  in  1  requester 0 has a frame
- `req0_data`  in  4  requester 0 frame; bit 3 is sent first
- `req0_ready`  out  1  requester 0 frame accepted this cycle (combinational)
- `req1_valid`  in  1  requester 1 has a frame
- `req1_data`  in  4  requester 1 frame; bit 3 is sent first
- `req1_ready`  out  1  requester 1 frame accepted this cycle (combinational)
- `det_rst_n`  out  1  drives the detector's `rst_n`
- `det_in`  out  1  drives the detector's `in`
- `det_dec`  in  1  the detector's `dec` (combinational in the detector)
- `res_valid`  out  1  one-cycle result pulse
- `res_match`  out  1  captured `det_dec` for the frame
- `res_id`  out  1  requester that owned the frame
- `match_cnt0`  out  CNT_W  matches for requester 0, saturating
- `match_cnt1`  out  CNT_W  matches for requester 1, saturating
- `busy`  out  1  state is not IDLE

## Operation
- **States:** IDLE, SYNC, SHIFT. A 2-bit bit index `bidx` counts 0..3 within SHIFT. A round-robin pointer `rr` is reset to 0, giving requester 0 priority.
- **Grant:**
  - A grant opportunity exists in IDLE, and in SHIFT when `bidx`==3.
  - Requester `rr` wins if valid; otherwise the other requester wins if valid.
  - Only the winner's `ready` is high; the handshake completes on valid&ready.
  - On a grant, the frame and id are latched and `rr` becomes the other requester's index.
- **IDLE:**
  - Outputs: `det_in`=0, `det_rst_n`=1.
  - On a grant, go to SYNC.
- **SYNC:**
  - Lasts one cycle with `det_rst_n`=0, `det_in`=0.
  - This aligns the detector's free-running 4-cycle counter to the frame.
  - Next state: SHIFT with `bidx`=0.
- **SHIFT:**
  - `det_in` = latched `frame[3-bidx]`.
  - At `bidx`==3, `det_dec` is registered into `res_match`, together with `res_id`; `res_valid` pulses on the next cycle.
  - At `bidx`==3 with a grant, stay in SHIFT with `bidx`=0 and no SYNC. The detector self-resets at its count of 3, so back-to-back frames stay aligned.
  - At `bidx`==3 without a grant, go to IDLE. After an idle gap the detector counter is unaligned, so the next frame must pass through SYNC.
- **Counters:** the owner's counter increments when a captured result has match=1; it holds at 2^CNT_W−1.
- **Expected matches:** exactly the frames 4'b0111, 4'b1001 and 4'b1110; all others give 0.
- **Reset** (rst_n low at any edge, including mid-frame):
  - State IDLE, `bidx`=0, `rr`=0.
  - `res_valid`=0, `res_match`=0, `res_id`=0, counters 0.
  - `det_rst_n`=0 while `rst_n` is low; `det_in`=0; both readys 0.
  - Any in-flight frame is dropped with no result.

## Timing
- Accept in cycle T from IDLE:
  - SYNC in T+1.
  - Bits 3,2,1,0 on `det_in` in T+2..T+5.
  - `det_dec` sampled at T+5.
  - `res_valid` high in T+6.
  - Total latency: 6 cycles.
- Back-to-back: the next accept is in T+5; its bit 3 is driven in T+6. Sustained throughput is one frame per 4 cycles.
- Simultaneous valids: the `rr` requester goes first and the other wins the next opportunity, so grants alternate strictly under continuous load.
- `ready` never asserts in SYNC, or in SHIFT with `bidx`≠3.
- Frame data must be stable only in the accept cycle.
- `res_valid` is a single-cycle pulse with no backpressure. `res_match` and `res_id` hold their values until the next pulse.

## Test plan
- **Single frame:** after reset, req0 sends 4'b0111 at T → SYNC at T+1; `det_in` = 0,1,1,1 over T+2..T+5; `res_valid`=1, `res_match`=1, `res_id`=0 at T+6; `match_cnt0`=1.
- **Non-matching frame:** req1 sends 4'b0110 → `res_match`=0 and `res_id`=1 at T+6; `match_cnt1` unchanged.
- **Contention:** both requesters hold valid with frames 1001 (req0) and 1110 (req1) → grants alternate 0,1,0,1 with no SYNC between frames; every result has match=1; `res_valid` occurs every 4 cycles.
- **Idle gap:** frame, then 3 idle cycles, then 4'b1110 → SYNC (`det_rst_n`=0 for exactly one cycle) precedes the second frame; `res_match`=1.
- **Mid-frame reset:** `rst_n` low during the `bidx`==1 cycle → next cycle shows IDLE, counters 0, no `res_valid`; a following 0111 frame behaves exactly as in the single-frame scenario.
- **Saturation:** with `CNT_W`=2, send five matching frames from req0 → `match_cnt0` reads 1,2,3,3,3.
